// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam logic [7:0]  DEF_PATTERN = 8'b0000_1101;
    localparam int unsigned DEF_LEN     = 4;
    localparam logic        DEF_OVERLAP = 1'b1;

    // Force a requested pattern length into the legal range 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        int unsigned res;
        res = len;
        if (len == 0) begin
            res = 1;
        end else if (len > max_len) begin
            res = max_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// Combinational masked compare: newest len history bits against the pattern,
// qualified by enough valid history being present.
module seq_match_cmp #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] hist_n_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [LEN_W-1:0]   fill_n_i,
    output logic               match_c_o
);

    logic [MAX_LEN-1:0] mask_c;

    // Select bit positions below len; bits at and above len are don't-care.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask_c[i] = (LEN_W'(i) < len_i);
        end
    end

    assign match_c_o = (((hist_n_i ^ pattern_i) & mask_c) == '0) && (fill_n_i >= len_i);

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with valid qualifier,
// overlap control and a saturating match counter.
module seq_detect_prog #(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          LEN_W       = 4,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(seq_det_pkg::DEF_PATTERN),
    parameter int unsigned          DEF_LEN     = seq_det_pkg::DEF_LEN,
    parameter logic                 DEF_OVERLAP = seq_det_pkg::DEF_OVERLAP
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               x,
    input  logic               x_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill
);
    import seq_det_pkg::clamp_len;

    localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_LEN_C = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [MAX_LEN-1:0] hist_q,    hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q,     len_d;
    logic [LEN_W-1:0]   fill_q,    fill_d;
    logic               overlap_q, overlap_d;
    logic               y_q,       y_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;

    logic [MAX_LEN-1:0] hist_n_c;
    logic [LEN_W-1:0]   fill_n_c;
    logic               match_c;
    logic               accept_c;
    logic               unused_oldest_c;

    // Candidate history/fill as they would be if the current sample is taken.
    assign accept_c        = x_valid & ~cfg_load;
    assign hist_n_c        = {hist_q[MAX_LEN-2:0], x};
    assign fill_n_c        = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);
    assign unused_oldest_c = hist_q[MAX_LEN-1];

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .hist_n_i  (hist_n_c),
        .pattern_i (pattern_q),
        .len_i     (len_q),
        .fill_n_i  (fill_n_c),
        .match_c_o (match_c)
    );

    // Next-state: config load restarts detection, else an accepted sample shifts in.
    always_comb begin
        hist_d    = hist_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        y_d       = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            len_d     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
            overlap_d = cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (x_valid) begin
            hist_d = hist_n_c;
            y_d    = match_c;
            // Non-overlapping mode needs a full fresh window after each hit.
            fill_d = (match_c && !overlap_q) ? '0 : fill_n_c;
        end

        if (count_clr) begin
            cnt_d = '0;
        end else if (accept_c && match_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset to the build-time defaults.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hist_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN_C;
            fill_q    <= '0;
            overlap_q <= DEF_OVERLAP;
            y_q       <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            fill_q    <= fill_d;
            overlap_q <= overlap_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
        end
    end

    assign y           = y_q;
    assign match_count = cnt_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;

    logic               CLK = 1'b0;
    logic               RESET;
    logic               x;
    logic               x_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               count_clr;
    logic               y;
    logic [CNT_W-1:0]   match_count;
    logic [LEN_W-1:0]   fill;

    int checks   = 0;
    int failures = 0;

    // Reference model: the accepted bits since the last restart, oldest first.
    int mq[$];
    int m_pat;
    int m_len;
    int m_ovl;
    int m_cnt;
    int m_y;

    typedef struct {
        bit ld;
        bit xv;
        bit xb;
        int ey;
        int ecnt;
        int efill;
    } vec_t;

    vec_t tbl[15];

    always #5 CLK = ~CLK;

    seq_detect_prog #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .x           (x),
        .x_valid     (x_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .y           (y),
        .match_count (match_count),
        .fill        (fill)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance the model by one clock using the inputs presented at the edge.
    task automatic model_step();
        int hit;
        hit = 0;
        if (RESET) begin
            m_pat = 'b1101;
            m_len = 4;
            m_ovl = 1;
            m_cnt = 0;
            mq.delete();
        end else begin
            if (cfg_load) begin
                m_pat = int'(cfg_pattern);
                m_len = int'(cfg_len);
                if (m_len == 0) m_len = 1;
                if (m_len > int'(MAX_LEN)) m_len = int'(MAX_LEN);
                m_ovl = int'(cfg_overlap);
                mq.delete();
            end else if (x_valid) begin
                mq.push_back(int'(x));
                if (mq.size() > int'(MAX_LEN)) void'(mq.pop_front());
                if (mq.size() >= m_len) begin
                    hit = 1;
                    for (int k = 0; k < m_len; k++) begin
                        if (mq[mq.size() - 1 - k] != ((m_pat >> k) & 1)) hit = 0;
                    end
                end
                if (hit != 0 && m_ovl == 0) mq.delete();
            end
            if (count_clr) m_cnt = 0;
            else if (hit != 0 && m_cnt < CNT_SAT) m_cnt++;
        end
        m_y = hit;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic apply(input bit rst, input bit ld, input bit xv, input bit xb, input bit cc);
        RESET     = rst;
        cfg_load  = ld;
        x_valid   = xv;
        x         = xb;
        count_clr = cc;
        tick();
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input int len, input bit ovl, input bit cc);
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        apply(1'b0, 1'b1, 1'b0, 1'b0, cc);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".y"},     int'(y),           m_y);
        chk({tag, ".count"}, int'(match_count), m_cnt);
        chk({tag, ".fill"},  int'(fill),        mq.size());
    endtask

    initial begin
        logic [MAX_LEN-1:0] p8;

        RESET = 1'b1; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.y", int'(y), 0);
        chk("reset.count", int'(match_count), 0);
        chk("reset.fill", int'(fill), 0);

        // Default 1101 overlapping, then reload as non-overlapping with a cleared count.
        tbl = '{
            '{0, 1, 1, 0, 0, 1}, '{0, 1, 1, 0, 0, 2}, '{0, 1, 0, 0, 0, 3},
            '{0, 1, 1, 1, 1, 4}, '{0, 1, 1, 0, 1, 5}, '{0, 1, 0, 0, 1, 6},
            '{0, 1, 1, 1, 2, 7},
            '{1, 0, 0, 0, 0, 0},
            '{0, 1, 1, 0, 0, 1}, '{0, 1, 1, 0, 0, 2}, '{0, 1, 0, 0, 0, 3},
            '{0, 1, 1, 1, 1, 0}, '{0, 1, 1, 0, 1, 1}, '{0, 1, 0, 0, 1, 2},
            '{0, 1, 1, 0, 1, 3}
        };
        cfg_pattern = MAX_LEN'('b1101);
        cfg_len     = LEN_W'(4);
        cfg_overlap = 1'b0;
        for (int i = 0; i < 15; i++) begin
            apply(1'b0, tbl[i].ld, tbl[i].xv, tbl[i].xb, tbl[i].ld);
            chk($sformatf("tbl%0d.y", i),     int'(y),           tbl[i].ey);
            chk($sformatf("tbl%0d.count", i), int'(match_count), tbl[i].ecnt);
            chk($sformatf("tbl%0d.fill", i),  int'(fill),        tbl[i].efill);
        end

        // Gaps in x_valid hold state and keep y low.
        load_cfg(MAX_LEN'('b1101), 4, 1'b1, 1'b1);
        check_model("gap.ld");
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("gap%0d.y", i), int'(y), 0);
            chk($sformatf("gap%0d.fill", i), int'(fill), 3);
        end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("gap.end.y", int'(y), 1);
        chk("gap.end.count", int'(match_count), 1);

        // Full-length pattern, then an over-range length that clamps to MAX_LEN.
        p8 = 8'b1010_0111;
        for (int pass = 0; pass < 2; pass++) begin
            load_cfg(p8, (pass == 0) ? 8 : 15, 1'b0, 1'b1);
            for (int b = 7; b >= 0; b--) begin
                apply(1'b0, 1'b0, 1'b1, p8[b], 1'b0);
                check_model($sformatf("len8.p%0d.b%0d", pass, b));
            end
            chk($sformatf("len8.p%0d.hit", pass), int'(y), 1);
        end

        // Length 0 clamps to 1: every valid 1 pulses.
        load_cfg(MAX_LEN'(1), 0, 1'b1, 1'b0);
        p8 = 8'b0000_1101;
        for (int b = 3; b >= 0; b--) begin
            apply(1'b0, 1'b0, 1'b1, p8[b], 1'b0);
            chk($sformatf("len0.b%0d.y", b), int'(y), int'(p8[b]));
        end

        // Counter saturation and clear priority over a simultaneous hit.
        load_cfg(MAX_LEN'(1), 1, 1'b1, 1'b1);
        for (int i = 0; i < CNT_SAT + 5; i++) apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("sat.count", int'(match_count), CNT_SAT);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr.y", int'(y), 1);
        chk("clr.count", int'(match_count), 0);

        // Reset mid-pattern, then cfg_load colliding with a valid sample.
        load_cfg(MAX_LEN'('b1101), 4, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst.fill", int'(fill), 0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst.next.y", int'(y), 0);
        chk("rst.next.fill", int'(fill), 1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ldx.fill", int'(fill), 0);
        chk("ldx.y", int'(y), 0);
        check_model("ldx");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = LEN_W'($urandom_range(0, 15));
            cfg_overlap = 1'($urandom);
            apply(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 99) == 0));
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
